// File: rtl/count_mod_n_if.sv
// Control and status bundle for the count_mod_n modulo counter.
// The master drives the counting controls; the counter (slave) returns count and flags.
interface count_mod_n_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    logic             up;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;
    logic             ovf;

    modport master (
        output en, up, clr, load, load_val,
        input  q, tc, wrap, ovf
    );

    modport slave (
        input  en, up, clr, load, load_val,
        output q, tc, wrap, ovf
    );
endinterface

// File: rtl/count_mod_n.sv
// Parametrised synchronous modulo counter: up/down, parallel load, sync clear,
// wrap or saturate at the bounds, combinational terminal count and sticky overflow.
module count_mod_n #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MAX   = 15,
    parameter bit          SAT   = 1'b0
) (
    input logic         clk,
    input logic         rst,
    count_mod_n_if.slave bus
);

    localparam longint unsigned MAX_LEGAL = (64'd1 << WIDTH) - 64'd1;

    // Reject parameter combinations the counter cannot represent.
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("count_mod_n: WIDTH=%0d outside 1..32", WIDTH);
    end
    if (MAX < 1 || 64'(MAX) > MAX_LEGAL) begin : g_bad_max
        $error("count_mod_n: MAX=%0d outside 1..2^WIDTH-1", MAX);
    end

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX);

    logic [WIDTH-1:0] q_r;
    logic             wrap_r;
    logic             ovf_r;

    logic             at_max;
    logic             at_zero;
    logic             at_bound;
    logic [WIDTH-1:0] step_q;
    logic [WIDTH-1:0] load_q;

    assign at_max   = (q_r == MAX_Q);
    assign at_zero  = (q_r == '0);
    assign at_bound = bus.up ? at_max : at_zero;

    // Bound checks use MAX, so q + 1 never carries out and q - 1 never borrows.
    always_comb begin
        step_q = q_r;
        if (bus.up) begin
            if (at_max) begin
                step_q = SAT ? MAX_Q : '0;
            end else begin
                step_q = q_r + WIDTH'(1);
            end
        end else begin
            if (at_zero) begin
                step_q = SAT ? '0 : MAX_Q;
            end else begin
                step_q = q_r - WIDTH'(1);
            end
        end
    end

    assign load_q = (bus.load_val > MAX_Q) ? MAX_Q : bus.load_val;

    // Priority: rst > clr > load > en.
    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            q_r    <= '0;
            wrap_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (bus.load) begin
            q_r    <= load_q;
            wrap_r <= 1'b0;
        end else if (bus.en) begin
            q_r    <= step_q;
            wrap_r <= at_bound && !SAT;
            ovf_r  <= ovf_r || at_bound;
        end else begin
            wrap_r <= 1'b0;
        end
    end

    // tc depends only on q, en and up so it can drive the next stage's en directly.
    assign bus.tc   = bus.en && at_bound;
    assign bus.q    = q_r;
    assign bus.wrap = wrap_r;
    assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_count_mod_n.sv
// Self-checking bench for count_mod_n: directed scenarios plus randomized
// stimulus against an arithmetic reference model.
module tb_count_mod_n;

    localparam int unsigned W = 4;
    localparam int          M = 9;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    logic rst_c;

    int n_vec = 0;
    int n_err = 0;

    count_mod_n_if #(.WIDTH(W)) bus_a ();
    count_mod_n_if #(.WIDTH(W)) bus_b ();
    count_mod_n_if #(.WIDTH(W)) bus_c0 ();
    count_mod_n_if #(.WIDTH(W)) bus_c1 ();

    count_mod_n #(.WIDTH(W), .MAX(9), .SAT(1'b0)) dut_a  (.clk(clk), .rst(rst_a), .bus(bus_a));
    count_mod_n #(.WIDTH(W), .MAX(9), .SAT(1'b1)) dut_b  (.clk(clk), .rst(rst_b), .bus(bus_b));
    count_mod_n #(.WIDTH(W), .MAX(9), .SAT(1'b0)) dut_c0 (.clk(clk), .rst(rst_c), .bus(bus_c0));
    count_mod_n #(.WIDTH(W), .MAX(9), .SAT(1'b0)) dut_c1 (.clk(clk), .rst(rst_c), .bus(bus_c1));

    assign bus_c1.en = bus_c0.tc;

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: counts modulo M+1 (wrap) or clamps to 0..M (saturate).
    task automatic model_step(input bit sat, input bit r, input bit c, input bit ld,
                              input bit e, input bit u, input int lv,
                              inout int mq, inout bit mw, inout bit mo);
        int nxt;
        if (r || c) begin
            mq = 0; mw = 1'b0; mo = 1'b0;
        end else if (ld) begin
            mq = (lv > M) ? M : lv;
            mw = 1'b0;
        end else if (e) begin
            nxt = u ? mq + 1 : mq - 1;
            if (nxt > M || nxt < 0) begin
                mo = 1'b1;
                mw = !sat;
                mq = sat ? ((nxt < 0) ? 0 : M) : (nxt + M + 1) % (M + 1);
            end else begin
                mq = nxt;
                mw = 1'b0;
            end
        end else begin
            mw = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1;
        bus_a.en = 1'b1; bus_a.up = 1'b1; bus_b.en = 1'b1; bus_b.up = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (bus_a.q !== 4'd0 || bus_a.wrap !== 1'b0 || bus_a.ovf !== 1'b0) begin
                n_err++;
                $display("FAIL reset_a cycle %0d: q=%0d wrap=%b ovf=%b, want 0/0/0", i, bus_a.q, bus_a.wrap, bus_a.ovf);
            end
            n_vec++;
            if (bus_b.q !== 4'd0 || bus_b.wrap !== 1'b0 || bus_b.ovf !== 1'b0) begin
                n_err++;
                $display("FAIL reset_b cycle %0d: q=%0d wrap=%b ovf=%b, want 0/0/0", i, bus_b.q, bus_b.wrap, bus_b.ovf);
            end
        end
        rst_a = 1'b0; rst_b = 1'b0; bus_a.en = 1'b0; bus_b.en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_vec++;
            if (bus_a.q !== 4'd0 || bus_a.wrap !== 1'b0) begin
                n_err++;
                $display("FAIL reset_hold cycle %0d: q=%0d wrap=%b, want 0/0", i, bus_a.q, bus_a.wrap);
            end
        end
        bus_a.en = 1'b1; bus_a.up = 1'b0;
        #1;
        n_vec++;
        if (bus_a.tc !== 1'b1) begin
            n_err++;
            $display("FAIL reset_tc_down: tc=%b want 1", bus_a.tc);
        end
        bus_a.up = 1'b1;
        #1;
        n_vec++;
        if (bus_a.tc !== 1'b0) begin
            n_err++;
            $display("FAIL reset_tc_up: tc=%b want 0", bus_a.tc);
        end
        bus_a.en = 1'b0;
    endtask

    task automatic test_up_wrap();
        int exp_q;
        rst_a = 1'b1; tick(); rst_a = 1'b0;
        bus_a.en = 1'b1; bus_a.up = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            n_vec++;
            if (bus_a.tc !== ((i % 10) == 9)) begin
                n_err++;
                $display("FAIL up_wrap_tc cycle %0d: tc=%b want %b", i, bus_a.tc, ((i % 10) == 9));
            end
            tick();
            exp_q = (i + 1) % 10;
            n_vec++;
            if (bus_a.q !== W'(exp_q) || bus_a.wrap !== (exp_q == 0) || bus_a.ovf !== (i >= 9)) begin
                n_err++;
                $display("FAIL up_wrap cycle %0d: q=%0d wrap=%b ovf=%b, want %0d/%b/%b",
                         i, bus_a.q, bus_a.wrap, bus_a.ovf, exp_q, (exp_q == 0), (i >= 9));
            end
        end
        bus_a.en = 1'b0;
    endtask

    task automatic test_down_saturate();
        int exp_q;
        rst_b = 1'b1; bus_b.en = 1'b0; tick(); rst_b = 1'b0;
        bus_b.load = 1'b1; bus_b.load_val = 4'd2; tick(); bus_b.load = 1'b0;
        n_vec++;
        if (bus_b.q !== 4'd2) begin
            n_err++;
            $display("FAIL sat_load: q=%0d want 2", bus_b.q);
        end
        bus_b.en = 1'b1; bus_b.up = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            exp_q = (2 - k < 0) ? 0 : 2 - k;
            n_vec++;
            if (bus_b.q !== W'(exp_q) || bus_b.wrap !== 1'b0 || bus_b.ovf !== (k >= 3)) begin
                n_err++;
                $display("FAIL sat_down step %0d: q=%0d wrap=%b ovf=%b, want %0d/0/%b",
                         k, bus_b.q, bus_b.wrap, bus_b.ovf, exp_q, (k >= 3));
            end
        end
        bus_b.en = 1'b0;
    endtask

    task automatic test_load_priority();
        rst_a = 1'b1; tick(); rst_a = 1'b0;
        bus_a.load = 1'b1; bus_a.load_val = 4'd13; bus_a.en = 1'b0; tick();
        n_vec++;
        if (bus_a.q !== 4'd9 || bus_a.ovf !== 1'b0) begin
            n_err++;
            $display("FAIL load_clamp: q=%0d ovf=%b, want 9/0", bus_a.q, bus_a.ovf);
        end
        bus_a.en = 1'b1; bus_a.up = 1'b1;
        #1;
        n_vec++;
        if (bus_a.tc !== 1'b1) begin
            n_err++;
            $display("FAIL tc_ignores_load: tc=%b want 1", bus_a.tc);
        end
        bus_a.load = 1'b0; tick();
        n_vec++;
        if (bus_a.q !== 4'd0 || bus_a.wrap !== 1'b1 || bus_a.ovf !== 1'b1) begin
            n_err++;
            $display("FAIL load_then_wrap: q=%0d wrap=%b ovf=%b, want 0/1/1", bus_a.q, bus_a.wrap, bus_a.ovf);
        end
        bus_a.load = 1'b1; bus_a.load_val = 4'd4; tick();
        n_vec++;
        if (bus_a.q !== 4'd4 || bus_a.wrap !== 1'b0 || bus_a.ovf !== 1'b1) begin
            n_err++;
            $display("FAIL load_over_en: q=%0d wrap=%b ovf=%b, want 4/0/1", bus_a.q, bus_a.wrap, bus_a.ovf);
        end
        bus_a.clr = 1'b1; bus_a.load_val = 4'd7; tick();
        n_vec++;
        if (bus_a.q !== 4'd0 || bus_a.wrap !== 1'b0 || bus_a.ovf !== 1'b0) begin
            n_err++;
            $display("FAIL clr_over_load: q=%0d wrap=%b ovf=%b, want 0/0/0", bus_a.q, bus_a.wrap, bus_a.ovf);
        end
        bus_a.clr = 1'b0; bus_a.load_val = 4'd6; tick();
        bus_a.load = 1'b0;
        rst_a = 1'b1; bus_a.clr = 1'b1; bus_a.load = 1'b1; tick();
        n_vec++;
        if (bus_a.q !== 4'd0) begin
            n_err++;
            $display("FAIL reset_mid_count: q=%0d want 0", bus_a.q);
        end
        rst_a = 1'b0; bus_a.clr = 1'b0; bus_a.load = 1'b0; bus_a.en = 1'b0;
    endtask

    task automatic test_direction_flip();
        rst_a = 1'b1; tick(); rst_a = 1'b0;
        bus_a.load = 1'b1; bus_a.load_val = 4'd9; tick(); bus_a.load = 1'b0;
        bus_a.en = 1'b1; bus_a.up = 1'b0; tick();
        n_vec++;
        if (bus_a.q !== 4'd8 || bus_a.wrap !== 1'b0 || bus_a.ovf !== 1'b0) begin
            n_err++;
            $display("FAIL flip_down_at_max: q=%0d wrap=%b ovf=%b, want 8/0/0", bus_a.q, bus_a.wrap, bus_a.ovf);
        end
        bus_a.up = 1'b1; tick(); tick();
        n_vec++;
        if (bus_a.q !== 4'd0 || bus_a.wrap !== 1'b1 || bus_a.ovf !== 1'b1) begin
            n_err++;
            $display("FAIL flip_up_wrap: q=%0d wrap=%b ovf=%b, want 0/1/1", bus_a.q, bus_a.wrap, bus_a.ovf);
        end
        bus_a.up = 1'b0; tick();
        n_vec++;
        if (bus_a.q !== 4'd9 || bus_a.wrap !== 1'b1 || bus_a.ovf !== 1'b1) begin
            n_err++;
            $display("FAIL down_wrap: q=%0d wrap=%b ovf=%b, want 9/1/1", bus_a.q, bus_a.wrap, bus_a.ovf);
        end
        bus_a.en = 1'b0; tick();
        n_vec++;
        if (bus_a.q !== 4'd9 || bus_a.wrap !== 1'b0 || bus_a.ovf !== 1'b1) begin
            n_err++;
            $display("FAIL hold_after_wrap: q=%0d wrap=%b ovf=%b, want 9/0/1", bus_a.q, bus_a.wrap, bus_a.ovf);
        end
    endtask

    task automatic test_cascade();
        int wraps1;
        int bad_period;
        wraps1 = 0; bad_period = 0;
        rst_c = 1'b1; bus_c0.en = 1'b1; tick(); rst_c = 1'b0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            tick();
            if (bus_c1.wrap === 1'b1) wraps1++;
            if (bus_c0.wrap !== ((cyc % 10) == 0)) bad_period++;
            if (cyc == 37) begin
                n_vec++;
                if (bus_c1.q !== 4'd3 || bus_c0.q !== 4'd7) begin
                    n_err++;
                    $display("FAIL cascade_37: q1=%0d q0=%0d, want 3/7", bus_c1.q, bus_c0.q);
                end
            end
            if (cyc == 99) begin
                n_vec++;
                if (bus_c1.tc !== 1'b1) begin
                    n_err++;
                    $display("FAIL cascade_tc1_99: tc1=%b want 1", bus_c1.tc);
                end
            end
        end
        n_vec++;
        if (bus_c1.q !== 4'd0 || bus_c0.q !== 4'd0 || bus_c1.wrap !== 1'b1 || wraps1 != 1) begin
            n_err++;
            $display("FAIL cascade_100: q1=%0d q0=%0d wrap1=%b pulses=%0d, want 0/0/1/1",
                     bus_c1.q, bus_c0.q, bus_c1.wrap, wraps1);
        end
        n_vec++;
        if (bad_period != 0) begin
            n_err++;
            $display("FAIL cascade_period: %0d cycles with misplaced stage0 wrap, want 0", bad_period);
        end
        bus_c0.en = 1'b0;
    endtask

    task automatic test_random();
        int ma_q, mb_q, lva, lvb;
        bit ma_w, ma_o, mb_w, mb_o;
        bit ra, ca, la, ea, ua, rb, cb, lb, eb, ub;
        bit exp_tca, exp_tcb;
        ma_q = 0; mb_q = 0; ma_w = 0; ma_o = 0; mb_w = 0; mb_o = 0;
        rst_a = 1'b1; rst_b = 1'b1; tick(); rst_a = 1'b0; rst_b = 1'b0;
        for (int i = 0; i < 500; i++) begin
            ra = ($urandom_range(99) < 3);  rb = ($urandom_range(99) < 3);
            ca = ($urandom_range(99) < 4);  cb = ($urandom_range(99) < 4);
            la = ($urandom_range(99) < 10); lb = ($urandom_range(99) < 10);
            ea = ($urandom_range(99) < 75); eb = ($urandom_range(99) < 75);
            ua = ($urandom_range(99) < 55); ub = ($urandom_range(99) < 45);
            lva = int'($urandom_range(15)); lvb = int'($urandom_range(15));
            rst_a = ra; bus_a.clr = ca; bus_a.load = la; bus_a.en = ea; bus_a.up = ua; bus_a.load_val = W'(lva);
            rst_b = rb; bus_b.clr = cb; bus_b.load = lb; bus_b.en = eb; bus_b.up = ub; bus_b.load_val = W'(lvb);
            exp_tca = ea && (ua ? (ma_q == M) : (ma_q == 0));
            exp_tcb = eb && (ub ? (mb_q == M) : (mb_q == 0));
            #1;
            n_vec++;
            if (bus_a.tc !== exp_tca || bus_b.tc !== exp_tcb) begin
                n_err++;
                $display("FAIL rand_tc cycle %0d: tc_a=%b tc_b=%b, want %b/%b", i, bus_a.tc, bus_b.tc, exp_tca, exp_tcb);
            end
            model_step(1'b0, ra, ca, la, ea, ua, lva, ma_q, ma_w, ma_o);
            model_step(1'b1, rb, cb, lb, eb, ub, lvb, mb_q, mb_w, mb_o);
            tick();
            n_vec++;
            if (bus_a.q !== W'(ma_q) || bus_a.wrap !== ma_w || bus_a.ovf !== ma_o) begin
                n_err++;
                $display("FAIL rand_wrap cycle %0d: q=%0d wrap=%b ovf=%b, want %0d/%b/%b",
                         i, bus_a.q, bus_a.wrap, bus_a.ovf, ma_q, ma_w, ma_o);
            end
            n_vec++;
            if (bus_b.q !== W'(mb_q) || bus_b.wrap !== mb_w || bus_b.ovf !== mb_o) begin
                n_err++;
                $display("FAIL rand_sat cycle %0d: q=%0d wrap=%b ovf=%b, want %0d/%b/%b",
                         i, bus_b.q, bus_b.wrap, bus_b.ovf, mb_q, mb_w, mb_o);
            end
        end
        rst_a = 1'b0; rst_b = 1'b0;
        bus_a.en = 1'b0; bus_a.clr = 1'b0; bus_a.load = 1'b0;
        bus_b.en = 1'b0; bus_b.clr = 1'b0; bus_b.load = 1'b0;
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        bus_a.en = 1'b0; bus_a.up = 1'b1; bus_a.clr = 1'b0; bus_a.load = 1'b0; bus_a.load_val = '0;
        bus_b.en = 1'b0; bus_b.up = 1'b1; bus_b.clr = 1'b0; bus_b.load = 1'b0; bus_b.load_val = '0;
        bus_c0.en = 1'b0; bus_c0.up = 1'b1; bus_c0.clr = 1'b0; bus_c0.load = 1'b0; bus_c0.load_val = '0;
        bus_c1.up = 1'b1; bus_c1.clr = 1'b0; bus_c1.load = 1'b0; bus_c1.load_val = '0;

        test_reset();
        test_up_wrap();
        test_down_saturate();
        test_load_priority();
        test_direction_flip();
        test_cascade();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
